// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder with IDLE/RUN/DONE control.
// One full adder is reused for WIDTH clocks, LSB first, with the carry kept in a flop.
// Optional feature: define SERIAL_ADDER_CTRL_OVF_EN to add the signed 'overflow' output.

module fullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              fa_s, fa_c;
    logic              accept, last_bit;

    assign accept   = (state_q == StIdle) && start;
    assign last_bit = (state_q == StRun) && (cnt_q == LastBit);

    // The single shared adder cell, fed by the operand bit selected by the counter.
    fullAdder u_fa (
        .a_i (a_q[cnt_q]),
        .b_i (b_q[cnt_q]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, DONE always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == LastBit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StRun:   busy = 1'b1;
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath next state: capture on accept, shift one bit per RUN cycle, publish on last bit.
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = inA;
            b_d     = inB;
            carry_d = carryIn;
            cnt_d   = '0;
            shift_d = '0;
        end else if (state_q == StRun) begin
            shift_d = {fa_s, shift_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CntW'(1);
            if (last_bit) begin
                sum_d  = {fa_s, shift_q[WIDTH-1:1]};
                cout_d = fa_c;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum      = sum_q;
    assign carryOut = cout_q;

`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic ovf_q, ovf_d;

    // On the MSB, carry_q is the carry into the MSB and fa_c the carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (last_bit) begin
            ovf_d = carry_q ^ fa_c;
        end
    end

    // Overflow register, held like sum.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    // Overflow tracking not built.
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 directed vectors plus a WIDTH=2 sweep.
// Drivers push expected results; negedge monitors pop and compare on every done pulse.

module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance signals
    logic       start8, ci8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    // WIDTH=2 instance signals
    logic       start2, ci2, busy2, done2, co2;
    logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic       ov8, ov2;
`endif

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rstN     (rstN),
        .start    (start8),
        .inA      (a8),
        .inB      (b8),
        .carryIn  (ci8),
        .busy     (busy8),
        .done     (done8),
        .sum      (sum8),
        .carryOut (co8)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        ,
        .overflow (ov8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk      (clk),
        .rstN     (rstN),
        .start    (start2),
        .inA      (a2),
        .inB      (b2),
        .carryIn  (ci2),
        .busy     (busy2),
        .done     (done2),
        .sum      (sum2),
        .carryOut (co2)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        ,
        .overflow (ov2)
`endif
    );

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         due;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference for the WIDTH=2 sweep: plain integer addition, signed rule for overflow.
    function automatic exp_t model2(input logic [1:0] a, input logic [1:0] b, input logic ci,
                                    input int due);
        exp_t       e;
        logic [2:0] full;
        full  = {1'b0, a} + {1'b0, b} + {2'b00, ci};
        e.s   = {6'b0, full[1:0]};
        e.co  = full[2];
        e.ov  = (a[1] == b[1]) && (full[1] != a[1]);
        e.due = due;
        return e;
    endfunction

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rstN && done8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("w8_sum", sum8, e.s);
                chk("w8_carryOut", co8, e.co);
                chk("w8_done_cycle", cyc, e.due);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
                chk("w8_overflow", ov8, e.ov);
`endif
            end
        end
    end

    // Monitor for the WIDTH=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rstN && done2) begin
            if (q2.size() == 0) begin
                chk("w2_unexpected_done", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("w2_sum", sum2, e.s[1:0]);
                chk("w2_carryOut", co2, e.co);
                chk("w2_done_cycle", cyc, e.due);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
                chk("w2_overflow", ov2, e.ov);
`endif
            end
        end
    end

    task automatic wait_idle8();
        for (int i = 0; i < 40; i++) begin
            if (!busy8) return;
            @(negedge clk);
        end
        chk("w8_idle_timeout", 1, 0);
    endtask

    task automatic wait_idle2();
        for (int i = 0; i < 20; i++) begin
            if (!busy2) return;
            @(negedge clk);
        end
        chk("w2_idle_timeout", 1, 0);
    endtask

    // One WIDTH=8 operation with hand-computed expectations; operands are scrambled after accept.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic eco, input logic eov);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        ci8    = ci;
        e.s    = es;
        e.co   = eco;
        e.ov   = eov;
        e.due  = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        chk("w8_busy_in_run", busy8, 1);
        start8 = 1'b0;
        a8     = ~a;
        b8     = a ^ 8'h5A;
        ci8    = ~ci;
        wait_idle8();
    endtask

    task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        @(negedge clk);
        start2 = 1'b1;
        a2     = a;
        b2     = b;
        ci2    = ci;
        q2.push_back(model2(a, b, ci, cyc + 1 + 2));
        @(negedge clk);
        start2 = 1'b0;
        a2     = ~a;
        b2     = ~b;
        ci2    = ~ci;
        wait_idle2();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ha[4];
        logic [7:0] hb[4];
        logic       hc[4];
        logic [7:0] hs[4];
        logic       hco[4];
        int         acc;
        exp_t       e;

        rstN   = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        #3;
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_sum", sum8, 0);
        chk("reset_carryOut", co8, 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // Basic vectors, incl. full carry ripple, carryIn only, and signed overflow cases.
        issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        issue8(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
        issue8(8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0);

        // start held high: each accept is 10 edges after the previous one (WIDTH cycles of RUN,
        // one DONE, one IDLE), i.e. WIDTH+1 done-low cycles between done pulses.
        ha = '{8'h12, 8'hF0, 8'hC8, 8'h55};
        hb = '{8'h34, 8'h0F, 8'h64, 8'hAA};
        hc = '{1'b0, 1'b1, 1'b0, 1'b0};
        hs = '{8'h46, 8'h00, 8'h2C, 8'hFF};
        hco = '{1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        start8 = 1'b1;
        acc    = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            a8    = ha[k];
            b8    = hb[k];
            ci8   = hc[k];
            e.s   = hs[k];
            e.co  = hco[k];
            e.ov  = 1'b0;
            e.due = acc + 8;
            q8.push_back(e);
            @(negedge clk);
            a8  = 8'hA5 ^ 8'(k);
            b8  = 8'h3C;
            ci8 = ~hc[k];
            while (cyc < acc + 9) @(negedge clk);
            acc = acc + 10;
        end
        start8 = 1'b0;
        wait_idle8();

        // Reset in the middle of RUN (bit 3 up next): outputs clear at once, no done pulse.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h55;
        b8     = 8'h22;
        ci8    = 1'b0;
        acc    = cyc + 1;
        @(negedge clk);
        start8 = 1'b0;
        while (cyc < acc + 3) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_carryOut", co8, 0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        chk("abort_overflow", ov8, 0);
`endif
        #1 rstN = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done_queue", q8.size(), 0);
        issue8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // Exhaustive WIDTH=2 sweep over a, b and carryIn.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    issue2(2'(a), 2'(b), 1'(c));
                end
            end
        end

        repeat (4) @(negedge clk);
        chk("w8_queue_drained", q8.size(), 0);
        chk("w2_queue_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
